elastic_buffer_write_ctrl: RTL and testbench
============================================

# elastic_buffer_write_ctrl

Write-side controller for the RX elastic buffer, clocked by the recovered clock. It accepts 10-bit symbols, generates the buffer-memory write strobe and address, and exports a registered Gray write pointer to the read domain. The read pointer comes back through an internal synchronizer, from which the block computes occupancy. Under a watermark policy it autonomously deletes at most one SKP per SKP ordered set, and it flags overflow instead of overwriting unread data.

## Interface
- DATA_WIDTH, 10, symbol width; SKP and COM constants assume 10.
- BUFFER_DEPTH, 16, entries; power of two, at least 4.
- ADDR_W, $clog2(BUFFER_DEPTH), derived localparam; all pointers are ADDR_W+1 bits.
- HI_WATERMARK, BUFFER_DEPTH/2+2, occupancy at or above which SKP deletion is armed.
- SYNC_STAGES, 2, flop stages on gray_read_pointer; minimum 2.

- write_clk  in  1  recovered write clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  incoming symbol.
- write_enable  in  1  data_in is valid this cycle.
- buffer_mode  in  1  1 enables SKP deletion; 0 writes every symbol.
- gray_read_pointer  in  ADDR_W+1  read-domain Gray pointer, asynchronous to write_clk.
- mem_wr_en  out  1  memory write strobe, combinational.
- write_address  out  ADDR_W+1  binary write pointer; the memory uses the low ADDR_W bits.
- gray_write_pointer  out  ADDR_W+1  registered Gray pointer sent to the read domain.
- occupancy  out  ADDR_W+1  write pointer minus synchronized read pointer.
- Skp_Removed  out  1  one-cycle pulse per deleted SKP.
- overflow  out  1  one-cycle pulse per symbol dropped because the buffer is full.
- overflow_sticky  out  1  set by any overflow; cleared only by reset.

## Operation
- Symbol constants:
  - SKP = 10'b0011111001 or 10'b1100000110.
  - COM = 10'b0011111010 or 10'b1100000101.
- Synchronizer: gray_read_pointer passes through SYNC_STAGES flops, then Gray-to-binary to give rd_bin.
- Occupancy: occupancy = write_address - rd_bin, modulo 2^(ADDR_W+1).
  - full = (occupancy == BUFFER_DEPTH).
- delete_arm = buffer_mode && occupancy >= HI_WATERMARK.
- Ordered-set FSM (advances only on cycles with write_enable=1):
  - IDLE: on COM go to OS_OPEN; otherwise stay.
  - OS_OPEN:
    - on SKP with delete_arm, delete the symbol and go to OS_DONE;
    - on SKP without delete_arm, write it and stay;
    - on COM, stay (a new set starts);
    - on anything else, go to IDLE.
  - OS_DONE:
    - on SKP, write it (no second deletion) and stay;
    - on COM, go to OS_OPEN;
    - on anything else, go to IDLE.
- Deleted symbols are never written and never count as overflow, even when full.
- Symbol handling per write_enable cycle:
  - delete: mem_wr_en=0, Skp_Removed=1 on the next cycle.
  - keep and not full: mem_wr_en=1, write_address increments.
  - keep and full: mem_wr_en=0, overflow=1 on the next cycle, overflow_sticky set, pointer held.
- A SKP is deleted only inside an ordered set. A lone SKP seen in IDLE is always written.

## Timing
- Reset values: write_address=0, gray_write_pointer=0, synchronizer flops=0, occupancy=0, Skp_Removed=0, overflow=0, overflow_sticky=0, FSM=IDLE.
- Reset asserted mid-ordered-set abandons the set. Reset deassertion is synchronous to write_clk by upstream convention.
- mem_wr_en is valid in the same cycle as data_in. The memory captures at write_address on that write_clk edge.
- write_address and gray_write_pointer update on that same edge.
- gray_write_pointer is computed from the next binary value and registered. It is never a combinational decode of a register.
- The read pointer reaches occupancy SYNC_STAGES cycles after it changes. Full and occupancy are therefore pessimistic; they never under-report.
- Wrap: write_address rolls from 2^(ADDR_W+1)-1 to 0. The MSB flip distinguishes full from empty.
- Skp_Removed and overflow are registered, 1-cycle latency, and are never asserted together.
- write_enable=0: no state change. Outputs other than the pulses hold.

## Structure
- Shared package eb_pkg holds:
  - SKP_RDN, SKP_RDP, COM_RDN, COM_RDP;
  - the FSM state enum;
  - the gray2bin and bin2gray functions.
- Sub-module: gray_ptr_sync (SYNC_STAGES-flop Gray synchronizer, parametrised width). It is reused by the read-side controller.
- The binToGray conversion is reused for the write pointer.

## Test plan
- Basic fill: DEPTH=16, read pointer frozen at 0, 16 data writes. Expect write_address 0→16, occupancy=16, mem_wr_en high on all 16; the 17th write gives overflow=1 and overflow_sticky=1, with the pointer held at 16.
- SKP delete: occupancy 10, buffer_mode=1, stream COM,SKP,SKP,SKP. Expect exactly one Skp_Removed pulse, the first SKP dropped, and write_address advancing by 3.
- Mode off: same stream with buffer_mode=0. Expect no Skp_Removed and write_address advancing by 4.
- Below watermark: occupancy 5, COM,SKP,SKP. Expect no deletion. Then a COM starting a new set after occupancy rises to 12 gives exactly one deletion.
- Full with SKP: occupancy 16 inside an ordered set with delete armed. Expect the SKP deleted, Skp_Removed=1, overflow=0.
- Wrap and sync: a read side advancing its Gray pointer continuously for 100 cycles while writes stream. Expect occupancy to match the reference model delayed by SYNC_STAGES, a clean pointer wrap, and async rst_n mid-set returning all outputs to 0.

Source files
------------

// File: rtl/eb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eb_pkg : shared symbols, FSM states and Gray helpers for elastic buffers |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package eb_pkg;

    localparam logic [9:0] SKP_RDN = 10'b0011111001;
    localparam logic [9:0] SKP_RDP = 10'b1100000110;
    localparam logic [9:0] COM_RDN = 10'b0011111010;
    localparam logic [9:0] COM_RDP = 10'b1100000101;

    // Helpers work on a wide container; callers zero-extend and slice.
    localparam int GRAY_FN_W = 32;

    typedef logic [1:0] eb_state_t;
    localparam eb_state_t ST_IDLE    = 2'd0;
    localparam eb_state_t ST_OS_OPEN = 2'd1;
    localparam eb_state_t ST_OS_DONE = 2'd2;

    function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] gray);
        logic [GRAY_FN_W-1:0] bin;
        bin[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
        for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_ptr_sync : multi-flop synchronizer for a Gray-coded pointer         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gray_ptr_sync #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign gray_out = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/elastic_buffer_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | elastic_buffer_write_ctrl : RX elastic buffer write side, SKP deletion   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module elastic_buffer_write_ctrl
    import eb_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 16,
    parameter int HI_WATERMARK = BUFFER_DEPTH / 2 + 2,
    parameter int SYNC_STAGES  = 2,
    localparam int ADDR_W      = $clog2(BUFFER_DEPTH)
) (
    input  logic                  write_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  buffer_mode,
    input  logic [ADDR_W:0]       gray_read_pointer,
    output logic                  mem_wr_en,
    output logic [ADDR_W:0]       write_address,
    output logic [ADDR_W:0]       gray_write_pointer,
    output logic [ADDR_W:0]       occupancy,
    output logic                  Skp_Removed,
    output logic                  overflow,
    output logic                  overflow_sticky
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_wr_gray;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_gray;
    logic [PTR_W-1:0]     w_rd_bin;
    logic [PTR_W-1:0]     w_occ;
    logic [GRAY_FN_W-1:0] w_rd_bin_full;
    logic [GRAY_FN_W-1:0] w_wr_gray_full;
    logic                 w_unused_hi;
    logic                 w_full;
    logic                 w_del_arm;
    logic                 w_is_skp;
    logic                 w_is_com;
    logic                 w_delete;
    logic                 w_wr_en;
    logic                 w_ovf;
    logic                 r_skp_removed;
    logic                 r_overflow;
    logic                 r_overflow_sticky;
    eb_state_t            r_state;
    eb_state_t            w_state_nxt;

    gray_ptr_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk      (write_clk),
        .rst_n    (rst_n),
        .gray_in  (gray_read_pointer),
        .gray_out (w_rd_gray)
    );

    assign w_rd_bin_full  = gray2bin({{(GRAY_FN_W-PTR_W){1'b0}}, w_rd_gray});
    assign w_rd_bin       = w_rd_bin_full[PTR_W-1:0];
    assign w_wr_gray_full = bin2gray({{(GRAY_FN_W-PTR_W){1'b0}}, w_wr_ptr_nxt});
    assign w_unused_hi    = ^{w_rd_bin_full[GRAY_FN_W-1:PTR_W], w_wr_gray_full[GRAY_FN_W-1:PTR_W]};

    // Synchronized read pointer lags, so occupancy can only over-report.
    assign w_occ     = r_wr_ptr - w_rd_bin;
    assign w_full    = (w_occ == PTR_W'(BUFFER_DEPTH));
    assign w_del_arm = buffer_mode && (w_occ >= PTR_W'(HI_WATERMARK));
    assign w_is_skp  = (data_in == SKP_RDN) || (data_in == SKP_RDP);
    assign w_is_com  = (data_in == COM_RDN) || (data_in == COM_RDP);

    always_comb begin
        w_state_nxt = r_state;
        w_delete    = 1'b0;
        if (write_enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_com) w_state_nxt = ST_OS_OPEN;
                end
                ST_OS_OPEN: begin
                    if (w_is_skp) begin
                        if (w_del_arm) begin
                            w_delete    = 1'b1;
                            w_state_nxt = ST_OS_DONE;
                        end
                    end else if (!w_is_com) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_OS_DONE: begin
                    if (w_is_com)       w_state_nxt = ST_OS_OPEN;
                    else if (!w_is_skp) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A deleted SKP is neither written nor counted as overflow.
    assign w_wr_en      = write_enable && !w_delete && !w_full;
    assign w_ovf        = write_enable && !w_delete && w_full;
    assign w_wr_ptr_nxt = w_wr_en ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr          <= '0;
            r_wr_gray         <= '0;
            r_state           <= ST_IDLE;
            r_skp_removed     <= 1'b0;
            r_overflow        <= 1'b0;
            r_overflow_sticky <= 1'b0;
        end else begin
            r_wr_ptr          <= w_wr_ptr_nxt;
            r_wr_gray         <= w_wr_gray_full[PTR_W-1:0];
            r_state           <= w_state_nxt;
            r_skp_removed     <= w_delete;
            r_overflow        <= w_ovf;
            r_overflow_sticky <= r_overflow_sticky | w_ovf;
        end
    end

    assign mem_wr_en          = w_wr_en;
    assign write_address      = r_wr_ptr;
    assign gray_write_pointer = r_wr_gray;
    assign occupancy          = w_occ;
    assign Skp_Removed        = r_skp_removed;
    assign overflow           = r_overflow;
    assign overflow_sticky    = r_overflow_sticky;

endmodule
`default_nettype wire

// File: tb/tb_elastic_buffer_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_elastic_buffer_write_ctrl : directed self-checking bench              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_elastic_buffer_write_ctrl;

    localparam logic [9:0] SKP   = 10'b0011111001;
    localparam logic [9:0] SKP_P = 10'b1100000110;
    localparam logic [9:0] COM   = 10'b0011111010;
    localparam logic [9:0] DAT   = 10'b0101010101;

    logic       write_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] data_in = '0;
    logic       write_enable = 1'b0;
    logic       buffer_mode = 1'b0;
    logic [4:0] gray_read_pointer = '0;
    logic       mem_wr_en;
    logic [4:0] write_address;
    logic [4:0] gray_write_pointer;
    logic [4:0] occupancy;
    logic       Skp_Removed;
    logic       overflow;
    logic       overflow_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] wr_m;
    logic [4:0] rd_cur;
    logic [4:0] rd_d1;
    logic [4:0] occ_true;
    logic [4:0] exp_occ;
    logic       we6;

    always #5 write_clk = ~write_clk;

    elastic_buffer_write_ctrl dut (
        .write_clk          (write_clk),
        .rst_n              (rst_n),
        .data_in            (data_in),
        .write_enable       (write_enable),
        .buffer_mode        (buffer_mode),
        .gray_read_pointer  (gray_read_pointer),
        .mem_wr_en          (mem_wr_en),
        .write_address      (write_address),
        .gray_write_pointer (gray_write_pointer),
        .occupancy          (occupancy),
        .Skp_Removed        (Skp_Removed),
        .overflow           (overflow),
        .overflow_sticky    (overflow_sticky)
    );

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    // Presents one symbol, checks the same-cycle strobe, then clocks it in.
    task automatic sym(input logic [9:0] d, input logic exp_wr, input string tag);
        data_in      = d;
        write_enable = 1'b1;
        #1;
        chk({tag, ".wr_en"}, 32'(mem_wr_en), 32'(exp_wr));
        tick();
        write_enable = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] b);
        gray_read_pointer = g(b);
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, ".addr"},  32'(write_address), 32'd0);
        chk({tag, ".gray"},  32'(gray_write_pointer), 32'd0);
        chk({tag, ".occ"},   32'(occupancy), 32'd0);
        chk({tag, ".skp"},   32'(Skp_Removed), 32'd0);
        chk({tag, ".ovf"},   32'(overflow), 32'd0);
        chk({tag, ".stk"},   32'(overflow_sticky), 32'd0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;

        // Fill 16 entries with the read pointer frozen at 0.
        for (int i = 0; i < 16; i++) begin
            sym(DAT, 1'b1, "fill");
            chk("fill.addr", 32'(write_address), 32'(i + 1));
        end
        chk("fill.occ", 32'(occupancy), 32'd16);
        chk("fill.gray", 32'(gray_write_pointer), 32'd24);
        sym(DAT, 1'b0, "ovf17");
        chk("ovf17.ovf", 32'(overflow), 32'd1);
        chk("ovf17.stk", 32'(overflow_sticky), 32'd1);
        chk("ovf17.addr", 32'(write_address), 32'd16);
        chk("ovf17.skp", 32'(Skp_Removed), 32'd0);
        tick();
        chk("ovf.pulse", 32'(overflow), 32'd0);
        chk("ovf.stk_hold", 32'(overflow_sticky), 32'd1);

        // Read pointer 6 reaches occupancy only after two edges.
        gray_read_pointer = g(5'd6);
        tick();
        chk("sync.lag1", 32'(occupancy), 32'd16);
        tick();
        chk("sync.lag2", 32'(occupancy), 32'd10);

        // SKP delete at occupancy 10.
        buffer_mode = 1'b1;
        sym(COM, 1'b1, "del.com");
        chk("del.com.skp", 32'(Skp_Removed), 32'd0);
        sym(SKP, 1'b0, "del.skp1");
        chk("del.skp1.skp", 32'(Skp_Removed), 32'd1);
        chk("del.skp1.ovf", 32'(overflow), 32'd0);
        chk("del.skp1.addr", 32'(write_address), 32'd17);
        sym(SKP, 1'b1, "del.skp2");
        chk("del.skp2.skp", 32'(Skp_Removed), 32'd0);
        sym(SKP_P, 1'b1, "del.skp3");
        chk("del.skp3.skp", 32'(Skp_Removed), 32'd0);
        chk("del.addr", 32'(write_address), 32'd19);

        // Mode off: every symbol written.
        set_rd(5'd13);
        chk("off.occ", 32'(occupancy), 32'd6);
        buffer_mode = 1'b0;
        sym(COM, 1'b1, "off.com");
        for (int i = 0; i < 3; i++) begin
            sym(SKP, 1'b1, "off.skp");
            chk("off.skp.skp", 32'(Skp_Removed), 32'd0);
        end
        chk("off.addr", 32'(write_address), 32'd23);

        // Below watermark, then a new set once occupancy reaches 12.
        set_rd(5'd18);
        chk("low.occ", 32'(occupancy), 32'd5);
        buffer_mode = 1'b1;
        sym(COM, 1'b1, "low.com");
        sym(SKP, 1'b1, "low.skp1");
        chk("low.skp1.skp", 32'(Skp_Removed), 32'd0);
        sym(SKP, 1'b1, "low.skp2");
        chk("low.skp2.skp", 32'(Skp_Removed), 32'd0);
        chk("low.addr", 32'(write_address), 32'd26);
        for (int i = 0; i < 4; i++) sym(DAT, 1'b1, "low.dat");
        chk("hi.occ", 32'(occupancy), 32'd12);
        sym(COM, 1'b1, "hi.com");
        chk("hi.gray31", 32'(gray_write_pointer), 32'd16);
        sym(SKP, 1'b0, "hi.skp1");
        chk("hi.skp1.skp", 32'(Skp_Removed), 32'd1);
        chk("hi.skp1.addr", 32'(write_address), 32'd31);
        sym(SKP, 1'b1, "hi.skp2");
        chk("hi.skp2.skp", 32'(Skp_Removed), 32'd0);
        chk("hi.wrap.addr", 32'(write_address), 32'd0);
        chk("hi.wrap.gray", 32'(gray_write_pointer), 32'd0);
        chk("hi.wrap.occ", 32'(occupancy), 32'd14);

        // Full inside an armed ordered set.
        sym(COM, 1'b1, "full.com1");
        sym(COM, 1'b1, "full.com2");
        chk("full.occ", 32'(occupancy), 32'd16);
        sym(SKP, 1'b0, "full.skp1");
        chk("full.skp1.skp", 32'(Skp_Removed), 32'd1);
        chk("full.skp1.ovf", 32'(overflow), 32'd0);
        chk("full.skp1.addr", 32'(write_address), 32'd2);
        sym(SKP, 1'b0, "full.skp2");
        chk("full.skp2.skp", 32'(Skp_Removed), 32'd0);
        chk("full.skp2.ovf", 32'(overflow), 32'd1);

        // Lone SKP outside a set is always written.
        set_rd(5'd22);
        chk("lone.occ", 32'(occupancy), 32'd12);
        sym(DAT, 1'b1, "lone.dat");
        sym(SKP, 1'b1, "lone.skp");
        chk("lone.skp.skp", 32'(Skp_Removed), 32'd0);
        chk("lone.addr", 32'(write_address), 32'd4);

        // Streaming writes against a continuously advancing reader.
        buffer_mode = 1'b0;
        wr_m   = 5'd4;
        rd_cur = 5'd22;
        for (int i = 0; i < 100; i++) begin
            rd_d1    = rd_cur;
            occ_true = wr_m - rd_cur;
            if (occ_true > 5'd4) rd_cur = rd_cur + 5'd1;
            we6 = ((i % 5) != 0) && (occ_true < 5'd14);
            gray_read_pointer = g(rd_cur);
            data_in           = DAT;
            write_enable      = we6;
            #1;
            chk("wrap.wr_en", 32'(mem_wr_en), 32'(we6));
            tick();
            if (we6) wr_m = wr_m + 5'd1;
            exp_occ = wr_m - rd_d1;
            chk("wrap.addr", 32'(write_address), 32'(wr_m));
            chk("wrap.gray", 32'(gray_write_pointer), 32'(g(wr_m)));
            chk("wrap.occ", 32'(occupancy), 32'(exp_occ));
            chk("wrap.ovf", 32'(overflow), 32'd0);
        end
        write_enable = 1'b0;

        // Asynchronous reset in the middle of an ordered set.
        buffer_mode = 1'b1;
        sym(COM, 1'b1, "rst.com");
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.mid");
        gray_read_pointer = g(5'd20);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst.occ", 32'(occupancy), 32'd12);
        sym(SKP, 1'b1, "rst.skp");
        chk("rst.skp.skp", 32'(Skp_Removed), 32'd0);
        chk("rst.addr", 32'(write_address), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
